// File: rtl/vc_read_scheduler.sv
// Weighted round-robin read sequencer for the four per-VC QoS FIFOs.
// Optional QOS_SCHED_STRICT_VC3_EN: VC3 gets strict priority and can preempt VC0-2.
module vc_read_scheduler #(
    parameter int WEIGHT_W       = 3,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic                edit_weight,
    input  logic [1:0]          vc_assign,
    input  logic [WEIGHT_W-1:0] weight_assign,
    input  logic [3:0]          vc_empty,
    input  logic                out_ready,
    output logic [3:0]          lectura,
    output logic [1:0]          vc_sel,
    output logic                out_valid,
    output logic [1:0]          out_vc,
    output logic                busy,
    output logic [WEIGHT_W-1:0] credit
);

    typedef enum logic {ARB, SERVE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          vc_sel_q, vc_sel_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [WEIGHT_W-1:0] weight_q [4];
    logic                out_valid_q;
    logic [1:0]          out_vc_q;

    logic [3:0] elig;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       fire;
    logic       preempt;
    logic       keep_ptr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = ~vc_empty[i] & (weight_q[i] != '0);
        end
    end

    // Walk downwards so the candidate closest to ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
`ifdef QOS_SCHED_STRICT_VC3_EN
        if (elig[3]) begin
            found = 1'b1;
            pick  = 2'd3;
        end
`endif
    end

`ifdef QOS_SCHED_STRICT_VC3_EN
    assign preempt  = (vc_sel_q != 2'd3) & elig[3];
    assign keep_ptr = (vc_sel_q == 2'd3);
`else
    assign preempt  = 1'b0;
    assign keep_ptr = 1'b0;
`endif

    assign fire = (state_q == SERVE) & enb & out_ready
                & ~vc_empty[vc_sel_q] & (credit_q != '0);

    assign lectura = fire ? (4'b0001 << vc_sel_q) : 4'b0000;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        vc_sel_d = vc_sel_q;
        credit_d = credit_q;
        if (enb) begin
            unique case (state_q)
                ARB: begin
                    if (found) begin
                        vc_sel_d = pick;
                        credit_d = weight_q[pick];
                        state_d  = SERVE;
                    end
                end
                SERVE: begin
                    if (fire) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                        if ((credit_q == WEIGHT_W'(1)) || preempt) begin
                            state_d = ARB;
                            if (!keep_ptr) ptr_d = vc_sel_q + 2'd1;
                        end
                    end else if (vc_empty[vc_sel_q] || (credit_q == '0) || preempt) begin
                        credit_d = '0;
                        state_d  = ARB;
                        if (!keep_ptr) ptr_d = vc_sel_q + 2'd1;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            ptr_q       <= 2'd0;
            vc_sel_q    <= 2'd0;
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            vc_sel_q    <= vc_sel_d;
            credit_q    <= credit_d;
            out_valid_q <= fire;
            out_vc_q    <= vc_sel_q;
            if (edit_weight) weight_q[vc_assign] <= weight_assign;
        end
    end

    assign vc_sel    = vc_sel_q;
    assign out_valid = out_valid_q;
    assign out_vc    = out_vc_q;
    assign busy      = (state_q == SERVE);
    assign credit    = credit_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Self-checking bench for vc_read_scheduler: vector table, directed corners
// and randomized traffic against a behavioural reference model.
module tb_vc_read_scheduler;

    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enb;
    logic          edit_weight;
    logic [1:0]    vc_assign;
    logic [WW-1:0] weight_assign;
    logic [3:0]    vc_empty;
    logic          out_ready;
    logic [3:0]    lectura;
    logic [1:0]    vc_sel;
    logic          out_valid;
    logic [1:0]    out_vc;
    logic          busy;
    logic [WW-1:0] credit;

    vc_read_scheduler #(.WEIGHT_W(WW), .DEFAULT_WEIGHT(1)) dut (
        .clk(clk), .reset(reset), .enb(enb), .edit_weight(edit_weight),
        .vc_assign(vc_assign), .weight_assign(weight_assign),
        .vc_empty(vc_empty), .out_ready(out_ready), .lectura(lectura),
        .vc_sel(vc_sel), .out_valid(out_valid), .out_vc(out_vc),
        .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_serve, m_vc, m_cred, m_ptr, m_ov, m_ovc, m_fire, m_lect;
    int m_w [4];
    int cnt [4];
    bit use_cnt;

    typedef struct {
        logic [3:0] emp;
        logic       rdy;
        logic [3:0] lect;
        logic       bsy;
        int         cr;
        logic       ov;
        int         ovc;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_serve = 0; m_vc = 0; m_cred = 0; m_ptr = 0; m_ov = 0; m_ovc = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
    endfunction

    function automatic void m_comb();
        m_fire = (m_serve != 0 && enb && out_ready && !vc_empty[m_vc] && m_cred != 0) ? 1 : 0;
        m_lect = (m_fire != 0) ? (1 << m_vc) : 0;
    endfunction

    function automatic void m_edge();
        int nov  = m_fire;
        int novc = m_vc;
        if (enb) begin
            if (m_serve == 0) begin
                for (int k = 0; k < 4; k++) begin
                    int j = (m_ptr + k) % 4;
                    if (!vc_empty[j] && m_w[j] != 0) begin
                        m_serve = 1; m_vc = j; m_cred = m_w[j];
                        break;
                    end
                end
            end else if (m_fire != 0) begin
                m_cred = m_cred - 1;
                if (m_cred == 0) begin
                    m_serve = 0; m_ptr = (m_vc + 1) % 4;
                end
            end else if (vc_empty[m_vc]) begin
                m_serve = 0; m_ptr = (m_vc + 1) % 4; m_cred = 0;
            end
        end
        if (edit_weight) m_w[vc_assign] = int'(weight_assign);
        m_ov = nov; m_ovc = novc;
    endfunction

    task automatic step();
        #1;
        m_comb();
        chk("lectura", int'(lectura), m_lect);
        chk("busy", int'(busy), m_serve);
        chk("credit", int'(credit), m_cred);
        chk("vc_sel", int'(vc_sel), m_vc);
        chk("out_valid", int'(out_valid), m_ov);
        chk("out_vc", int'(out_vc), m_ovc);
        @(posedge clk);
        m_edge();
        if (use_cnt) begin
            for (int i = 0; i < 4; i++) if (m_lect[i]) cnt[i]--;
        end
        @(negedge clk);
        if (use_cnt) begin
            for (int i = 0; i < 4; i++) vc_empty[i] = (cnt[i] == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        enb = 1'b1; edit_weight = 1'b0; out_ready = 1'b1; use_cnt = 1'b0;
    endtask

    task automatic set_w(input int vc, input int w);
        edit_weight = 1'b1;
        vc_assign = 2'(vc);
        weight_assign = WW'(w);
        step();
        edit_weight = 1'b0;
    endtask

    initial begin
        bit saw3;
        reset = 1'b0; enb = 1'b1; edit_weight = 1'b0; vc_assign = 2'd0;
        weight_assign = '0; vc_empty = 4'h0; out_ready = 1'b1; use_cnt = 1'b0;
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_lectura", int'(lectura), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credit", int'(credit), 0);
        @(negedge clk);
        reset = 1'b1;

        // Default weights, all non-empty: single-word round robin
        tv[0] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 0};
        tv[1] = '{4'h0, 1'b1, 4'b0001, 1'b1, 1, 1'b0, 0};
        tv[2] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0, 1'b1, 0};
        tv[3] = '{4'h0, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 0};
        tv[4] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0, 1'b1, 1};
        tv[5] = '{4'h0, 1'b1, 4'b0100, 1'b1, 1, 1'b0, 0};
        tv[6] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0, 1'b1, 2};
        tv[7] = '{4'h0, 1'b1, 4'b1000, 1'b1, 1, 1'b0, 0};
        tv[8] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0, 1'b1, 3};
        tv[9] = '{4'h0, 1'b1, 4'b0001, 1'b1, 1, 1'b0, 0};
        for (int i = 0; i < 10; i++) begin
            vc_empty = tv[i].emp;
            out_ready = tv[i].rdy;
            #1;
            chk("tv_lectura", int'(lectura), int'(tv[i].lect));
            chk("tv_busy", int'(busy), int'(tv[i].bsy));
            chk("tv_credit", int'(credit), tv[i].cr);
            chk("tv_out_valid", int'(out_valid), int'(tv[i].ov));
            if (tv[i].ov) chk("tv_out_vc", int'(out_vc), tv[i].ovc);
            step();
        end

        // Weights 3,1,2,0: VC3 must never be read
        do_reset();
        vc_empty = 4'hF;
        set_w(0, 3); set_w(1, 1); set_w(2, 2); set_w(3, 0);
        vc_empty = 4'h0;
        saw3 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            saw3 |= lectura[3];
            step();
        end
        chk("t2_no_vc3", int'(saw3), 0);

        // VC1 weight 4 but only two words: early burst end, then VC2
        do_reset();
        vc_empty = 4'hF;
        set_w(0, 0); set_w(1, 4); set_w(2, 1); set_w(3, 0);
        use_cnt = 1'b1;
        cnt[0] = 0; cnt[1] = 2; cnt[2] = 5; cnt[3] = 0;
        vc_empty = 4'b1001;
        step(); step(); step();
        #1;
        chk("t3_credit_held", int'(credit), 2);
        chk("t3_no_read", int'(lectura), 0);
        step();
        #1;
        chk("t3_credit_zero", int'(credit), 0);
        chk("t3_busy_drop", int'(busy), 0);
        step();
        #1;
        chk("t3_next_vc2", int'(vc_sel), 2);
        chk("t3_busy", int'(busy), 1);
        step();
        use_cnt = 1'b0;

        // Back-pressure mid-burst
        do_reset();
        vc_empty = 4'hF;
        set_w(0, 3);
        vc_empty = 4'h0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            #1;
            chk("t4_stall_lect", int'(lectura), 0);
            chk("t4_stall_credit", int'(credit), 2);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_resume_lect", int'(lectura), 1);
            step();
        end
        #1;
        chk("t4_done_busy", int'(busy), 0);
        chk("t4_done_credit", int'(credit), 0);

        // All empty, then VC2 fills; then same with enb low
        do_reset();
        vc_empty = 4'hF;
        step(); step(); step();
        vc_empty = 4'b1011;
        #1;
        chk("t5_pre_busy", int'(busy), 0);
        step();
        #1;
        chk("t5_busy", int'(busy), 1);
        chk("t5_lect", int'(lectura), 4);
        step();
        do_reset();
        enb = 1'b0;
        vc_empty = 4'b1011;
        step(); step(); step();
        #1;
        chk("t5_frozen_busy", int'(busy), 0);
        chk("t5_frozen_lect", int'(lectura), 0);
        enb = 1'b1;

        // Asynchronous reset mid-burst
        do_reset();
        vc_empty = 4'hF;
        set_w(0, 5);
        vc_empty = 4'h0;
        step(); step();
        #1;
        chk("t6_mid_burst", int'(lectura), 1);
        reset = 1'b0;
        #1;
        chk("t6_async_lect", int'(lectura), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_credit", int'(credit), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        step();
        #1;
        chk("t6_first_vc", int'(vc_sel), 0);
        chk("t6_weight_default", int'(credit), 1);
        step();

        // Randomized traffic against the model
        do_reset();
        use_cnt = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = int'($urandom_range(0, 3));
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int r = int'($urandom_range(0, 3));
                cnt[r] += int'($urandom_range(1, 3));
            end
            for (int i = 0; i < 4; i++) vc_empty[i] = (cnt[i] == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            enb = ($urandom_range(0, 7) != 0);
            edit_weight = ($urandom_range(0, 9) == 0);
            vc_assign = 2'($urandom_range(0, 3));
            weight_assign = WW'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_read_scheduler.md
Name: vc_read_scheduler

Overview:
- Weighted round-robin read sequencer for the four per-VC FIFOs of the QoS path.
- Chooses which VC FIFO to pop and how many consecutive words to take, based on a programmable per-VC weight table, the FIFO empty flags and a downstream ready handshake.
- Drives the FIFO read strobes and the 4:1 output-mux select, and flags valid output data one cycle after each pop.

Parameters:
- WEIGHT_W, 3, width of each weight and of the credit counter.
- DEFAULT_WEIGHT, 1, weight loaded into all four VCs at reset. Must be < 2**WEIGHT_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enb  in  1  scheduling enable. Low freezes the state machine, credit and pointer.
- edit_weight  in  1  write strobe for the weight table.
- vc_assign  in  2  VC index written when edit_weight=1.
- weight_assign  in  WEIGHT_W  weight value written when edit_weight=1.
- vc_empty  in  4  per-VC FIFO empty flags.
- out_ready  in  1  downstream can accept one word this cycle.
- lectura  out  4  one-hot FIFO read strobes (combinational from registered state and inputs).
- vc_sel  out  2  VC currently granted; drives the mux select.
- out_valid  out  1  registered; mux output holds a word popped the previous cycle.
- out_vc  out  2  registered VC id of the word flagged by out_valid.
- busy  out  1  1 while in SERVE.
- credit  out  WEIGHT_W  remaining reads in the current burst.

Behaviour:
- Reset values: lectura=0, vc_sel=0, out_valid=0, out_vc=0, busy=0, credit=0, state=ARB, ptr=0, all weights=DEFAULT_WEIGHT.
- Eligible VC: vc_empty[i]=0 and weight[i]!=0. Weight 0 disables the VC.
- State ARB, each cycle with enb=1:
  - Search i = ptr, ptr+1, ... (mod 4) for the first eligible VC.
  - If found: vc_sel<=i, credit<=weight[i], state<=SERVE.
  - If none: stay in ARB.
  - lectura=0 throughout ARB.
- fire = (state==SERVE) & enb & out_ready & ~vc_empty[vc_sel] & (credit!=0).
- lectura = fire ? (1<<vc_sel) : 0.
- State SERVE, on fire: credit<=credit-1.
  - If credit==1: state<=ARB, ptr<=vc_sel+1 (wraps 3->0).
- State SERVE, no fire because vc_empty[vc_sel]=1: burst ends early. state<=ARB, ptr<=vc_sel+1, credit<=0.
- State SERVE, out_ready=0: hold state, credit and vc_sel. No read.
- One ARB bubble cycle separates consecutive bursts. The first pop occurs on the cycle after the grant edge.
- out_valid<=fire and out_vc<=vc_sel every edge, regardless of enb, to model FIFO read latency 1.
- Weight table:
  - Written at the clock edge when edit_weight=1, regardless of enb or state.
  - A grant in the same cycle as a write to that VC loads the old weight.
  - An edit to the VC being served does not change its running credit; the new weight applies at its next grant.
- Asynchronous reset mid-burst: all registers return to reset values immediately. lectura drops to 0 the same instant.

Optional Feature:
- Macro QOS_SCHED_STRICT_VC3_EN enables strict priority for VC3.
- Defined:
  - In ARB, an eligible VC3 is always granted, ignoring ptr.
  - In SERVE of VC0-2, if VC3 becomes eligible, the burst ends after the current cycle's fire, or immediately if there is no fire. state<=ARB and ptr<=vc_sel+1, so round-robin fairness among VC0-2 is kept.
  - Serving VC3 does not update ptr.
- Undefined: VC3 is an ordinary WRR participant. No preemption logic is synthesized.

Test Plan:
1. Default weights, vc_empty=0000, out_ready=1 -> lectura: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001, ... out_valid follows each pop by one cycle with out_vc = 0, 1, 2, 3.
2. Program weights 3,1,2,0; all non-empty -> bursts of VC0 x3, VC1 x1, VC2 x2, repeating. lectura[3] is never asserted.
3. weight[1]=4, VC1 holds 2 words -> two pops of VC1, vc_empty[1] rises, burst ends with credit=2->0. Next grant is VC2.
4. out_ready=0 for 3 cycles mid-burst (credit=2) -> lectura=0 and credit=2 held. On release, the remaining 2 pops complete.
5. All empty, then vc_empty[2] falls -> busy=1 after 1 edge, lectura=0100 during the next cycle. Same scenario with enb=0 -> nothing moves.
6. reset asserted mid-burst -> lectura=0000 immediately. After release: out_valid=0, weights=1, and the first grant is VC0.
